regfile: RTL and testbench
==========================

Name: regfile

Overview:
- 32 x 32-bit general-purpose register file; the responder side of the decode stage's two register read ports.
- Also accepts one write per cycle from write-back.
- After reset, an internal init sequencer clears every register before the file reports ready, so no X values propagate into the pipeline.
- A registered debug read port gives testbench/JTAG visibility without disturbing the pipeline ports.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width
- NUM_REGS, 32, number of registers (2**ADDR_W); register 0 hardwired to zero

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- we  in  1  write enable from write-back
- waddr  in  ADDR_W  write register address
- wdata  in  DATA_W  write data
- re1  in  1  read-port-1 enable
- raddr1  in  ADDR_W  read-port-1 address
- rdata1  out  DATA_W  read-port-1 data (combinational)
- re2  in  1  read-port-2 enable
- raddr2  in  ADDR_W  read-port-2 address
- rdata2  out  DATA_W  read-port-2 data (combinational)
- init_done  out  1  high once the clear sweep is complete; registered
- dbg_re  in  1  debug read request
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  debug read data, registered, 1-cycle latency
- dbg_valid  out  1  dbg_data holds a valid result this cycle

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Sequencer state: INIT or RUN, plus an ADDR_W-bit sweep counter.
- Reset (rst=1 at an edge):
  - state<=INIT, counter<=1, init_done<=0, dbg_valid<=0, dbg_data<=0.
  - Register contents are not otherwise modified.
- INIT:
  - At each edge with rst=0: mem[counter]<=0, counter<=counter+1.
  - When counter==NUM_REGS-1 at the edge, that register is cleared, and state<=RUN, init_done<=1.
  - init_done therefore rises after exactly NUM_REGS-1 (31) edges with rst low.
- INIT restrictions: external writes are ignored; rdata1/2 read 0; debug requests are ignored (dbg_valid stays 0).
- Reset during INIT or RUN aborts the current activity and restarts the sweep from counter=1.
- Write (RUN only):
  - At an edge with we=1 and waddr!=0: mem[waddr]<=wdata.
  - we=1 with waddr==0 has no effect.
- Read ports 1 and 2 (independent, identical, purely combinational). Priority, highest first:
  1. rst=1 or init_done=0 -> 0.
  2. reX=0 -> 0.
  3. raddrX==0 -> 0.
  4. we=1 and waddr==raddrX -> wdata (same-cycle write bypass).
  5. Otherwise -> mem[raddrX].
- Both ports may address the same register simultaneously; both return the same value, including the bypass value.
- Debug port:
  - At an edge in RUN with dbg_re=1: dbg_valid<=1 and dbg_data<=value.
  - value is 0 if dbg_addr==0; else wdata if we=1 and waddr==dbg_addr (bypass); else mem[dbg_addr].
  - With dbg_re=0: dbg_valid<=0 and dbg_data holds its previous value.
  - Back-to-back requests return one result per cycle.
- No other outputs are registered; no combinational path from the debug port to the pipeline ports.

Test Plan:
- Reset release: hold rst 3 cycles, then drop it and keep re1=1, raddr1=5 throughout -> rdata1=0 and init_done=0 for 31 edges; init_done=1 after the 31st edge; rdata1=0 afterwards.
- Write then read: we=1, waddr=3, wdata=32'hDEADBEEF for one cycle, then re1=1, raddr1=3 next cycle -> rdata1=32'hDEADBEEF.
- Bypass and dual port:
  - Same cycle: we=1, waddr=7, wdata=32'h1234_5678, re1=re2=1, raddr1=raddr2=7 -> both ports show 32'h1234_5678 that cycle.
  - Same cycle with re2=0 -> rdata2=0.
- Register 0: we=1, waddr=0, wdata=32'hFFFF_FFFF, then read raddr1=0 and debug dbg_addr=0 -> rdata1=0, dbg_data=0, dbg_valid=1 one cycle after the request.
- Reset mid-operation:
  - Setup: write r9=32'hA5A5_A5A5, then pulse rst for 1 cycle, then assert we=1, waddr=9 during the sweep.
  - During sweep: write ignored, init_done=0.
  - After 31 edges: reading r9 returns 0.
- Debug pipelining: dbg_re=1 for three cycles with dbg_addr=1,2,3 (pre-written 32'h11, 32'h22, 32'h33) -> dbg_data=11, 22, 33 on the following three cycles with dbg_valid=1; dbg_valid=0 on the cycle after dbg_re drops.

Source files
------------

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// Module   : regfile
// Purpose  : 32x32 register file. It has two combinational read ports with
//            write bypass, one write port, a registered debug read port, and
//            a post-reset clear sweep gated by init_done.
// Revision : 1.0
// ============================================================================
module regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              init_done,
    input  logic              dbg_re,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              dbg_valid
);

    localparam logic [0:0]        S_INIT = 1'b0;
    localparam logic [0:0]        S_RUN  = 1'b1;
    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] C_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] C_ZERO = '0;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_init_done;
    logic              r_dbg_valid;
    logic [DATA_W-1:0] r_dbg_data;
    logic [DATA_W-1:0] r_mem [NUM_REGS];

    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    // Register 0 reads as zero; a same-cycle write to the address wins over the array.
    function automatic logic [DATA_W-1:0] f_lookup(input logic [ADDR_W-1:0] a);
        if (a == C_ZERO)
            return '0;
        else if (we && (waddr == a))
            return wdata;
        else
            return r_mem[a];
    endfunction

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = r_cnt;
        w_mem_wdata = '0;
        if (!rst) begin
            if (r_state == S_INIT) begin
                w_mem_we = 1'b1;
            end else if (we && (waddr != C_ZERO)) begin
                w_mem_we    = 1'b1;
                w_mem_addr  = waddr;
                w_mem_wdata = wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[w_mem_addr] <= w_mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_INIT;
            r_cnt       <= C_ONE;
            r_init_done <= 1'b0;
            r_dbg_valid <= 1'b0;
            r_dbg_data  <= '0;
        end else if (r_state == S_INIT) begin
            r_cnt       <= r_cnt + C_ONE;
            r_dbg_valid <= 1'b0;
            if (r_cnt == C_LAST) begin
                r_state     <= S_RUN;
                r_init_done <= 1'b1;
            end
        end else begin
            r_dbg_valid <= dbg_re;
            if (dbg_re)
                r_dbg_data <= f_lookup(dbg_addr);
        end
    end

    assign w_rd1 = (rst || !r_init_done || !re1) ? '0 : f_lookup(raddr1);
    assign w_rd2 = (rst || !r_init_done || !re2) ? '0 : f_lookup(raddr2);

    assign rdata1    = w_rd1;
    assign rdata2    = w_rd2;
    assign init_done = r_init_done;
    assign dbg_data  = r_dbg_data;
    assign dbg_valid = r_dbg_valid;

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile
// Purpose  : Self-checking bench for regfile: vector table for the pipeline
//            ports plus a queue scoreboard for the one-cycle debug port.
// Revision : 1.0
// ============================================================================
module tb_regfile;

    logic        clk = 1'b0;
    logic        rst, we, re1, re2, dbg_re;
    logic [4:0]  waddr, raddr1, raddr2, dbg_addr;
    logic [31:0] wdata;
    logic [31:0] rdata1, rdata2, dbg_data;
    logic        init_done, dbg_valid;

    int n_checks = 0;
    int n_errors = 0;

    regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .init_done(init_done),
        .dbg_re(dbg_re), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_valid(dbg_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;  logic [4:0] waddr; logic [31:0] wdata;
        logic        re1; logic [4:0] ra1;
        logic        re2; logic [4:0] ra2;
        logic        dre; logic [4:0] da;
        logic [31:0] e1;  logic [31:0] e2; logic [31:0] ed;
    } vec_t;

    typedef struct {
        logic        v;
        logic [31:0] d;
    } sb_t;

    vec_t        vecs[18];
    sb_t         sbq[$];
    logic [31:0] dbg_last = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                                input logic r1, input logic [4:0] a1,
                                input logic r2, input logic [4:0] a2,
                                input logic dr, input logic [4:0] da,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input logic [31:0] ed);
        vec_t v;
        v.we = w;   v.waddr = wa; v.wdata = wd;
        v.re1 = r1; v.ra1 = a1;   v.re2 = r2; v.ra2 = a2;
        v.dre = dr; v.da = da;
        v.e1 = e1;  v.e2 = e2;    v.ed = ed;
        return v;
    endfunction

    task automatic idle_inputs();
        we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        dbg_re = 1'b0; dbg_addr = '0;
    endtask

    // Drive just after a rising edge, check at the falling edge, then advance.
    task automatic step(input vec_t v, input int idx);
        sb_t s;
        we = v.we; waddr = v.waddr; wdata = v.wdata;
        re1 = v.re1; raddr1 = v.ra1; re2 = v.re2; raddr2 = v.ra2;
        dbg_re = v.dre; dbg_addr = v.da;
        @(negedge clk);
        chk($sformatf("vec%0d rdata1", idx), rdata1, v.e1);
        chk($sformatf("vec%0d rdata2", idx), rdata2, v.e2);
        if (sbq.size() > 0) begin
            s = sbq.pop_front();
            chk($sformatf("vec%0d dbg_valid", idx), {31'b0, dbg_valid}, {31'b0, s.v});
            chk($sformatf("vec%0d dbg_data", idx), dbg_data, s.d);
        end
        if (v.dre) dbg_last = v.ed;
        s.v = v.dre;
        s.d = dbg_last;
        sbq.push_back(s);
        @(posedge clk); #1;
    endtask

    initial begin
        sb_t s;

        vecs[0]  = mk(1, 3,  32'hDEADBEEF, 0, 3,  0, 0,  0, 0,  32'h0,        32'h0,        32'h0);
        vecs[1]  = mk(0, 0,  32'h0,        1, 3,  1, 3,  0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0);
        vecs[2]  = mk(1, 7,  32'h12345678, 1, 7,  1, 7,  0, 0,  32'h12345678, 32'h12345678, 32'h0);
        vecs[3]  = mk(1, 8,  32'hCAFEF00D, 1, 8,  0, 8,  0, 0,  32'hCAFEF00D, 32'h0,        32'h0);
        vecs[4]  = mk(1, 0,  32'hFFFFFFFF, 1, 0,  1, 7,  1, 0,  32'h0,        32'h12345678, 32'h0);
        vecs[5]  = mk(0, 0,  32'h0,        1, 0,  1, 8,  1, 3,  32'h0,        32'hCAFEF00D, 32'hDEADBEEF);
        vecs[6]  = mk(1, 1,  32'h11,       1, 1,  0, 0,  1, 1,  32'h11,       32'h0,        32'h11);
        vecs[7]  = mk(1, 2,  32'h22,       1, 1,  0, 0,  1, 2,  32'h11,       32'h0,        32'h22);
        vecs[8]  = mk(1, 3,  32'h33,       0, 0,  1, 3,  1, 3,  32'h0,        32'h33,       32'h33);
        vecs[9]  = mk(0, 0,  32'h0,        1, 2,  0, 0,  0, 0,  32'h22,       32'h0,        32'h0);
        vecs[10] = mk(1, 31, 32'h80000001, 1, 31, 1, 31, 1, 31, 32'h80000001, 32'h80000001, 32'h80000001);
        vecs[11] = mk(0, 0,  32'h0,        0, 31, 1, 31, 1, 8,  32'h0,        32'h80000001, 32'hCAFEF00D);
        vecs[12] = mk(0, 0,  32'h0,        1, 3,  1, 7,  0, 0,  32'h33,       32'h12345678, 32'h0);
        vecs[13] = mk(0, 0,  32'h0,        0, 0,  0, 0,  1, 1,  32'h0,        32'h0,        32'h11);
        vecs[14] = mk(0, 0,  32'h0,        0, 0,  0, 0,  1, 2,  32'h0,        32'h0,        32'h22);
        vecs[15] = mk(0, 0,  32'h0,        0, 0,  0, 0,  1, 3,  32'h0,        32'h0,        32'h33);
        vecs[16] = mk(0, 0,  32'h0,        0, 0,  0, 0,  0, 0,  32'h0,        32'h0,        32'h0);
        vecs[17] = mk(0, 0,  32'h0,        1, 31, 0, 0,  0, 0,  32'h80000001, 32'h0,       32'h0);

        // Reset release and clear sweep; debug requests during the sweep must be ignored.
        idle_inputs();
        rst = 1'b1; re1 = 1'b1; raddr1 = 5'd5;
        repeat (3) @(posedge clk);
        #1;
        chk("reset init_done", {31'b0, init_done}, 32'h0);
        chk("reset dbg_valid", {31'b0, dbg_valid}, 32'h0);
        chk("reset dbg_data", dbg_data, 32'h0);
        rst = 1'b0; dbg_re = 1'b1; dbg_addr = 5'd0;
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            chk($sformatf("sweep%0d init_done", i), {31'b0, init_done}, 32'h0);
            chk($sformatf("sweep%0d rdata1", i), rdata1, 32'h0);
            chk($sformatf("sweep%0d dbg_valid", i), {31'b0, dbg_valid}, 32'h0);
            @(posedge clk); #1;
        end
        chk("sweep done init_done", {31'b0, init_done}, 32'h1);
        chk("sweep done rdata1 r5", rdata1, 32'h0);
        chk("sweep done dbg_valid", {31'b0, dbg_valid}, 32'h0);
        idle_inputs();

        for (int i = 0; i < 18; i++) step(vecs[i], i);
        @(negedge clk);
        while (sbq.size() > 0) begin
            s = sbq.pop_front();
            chk("tail dbg_valid", {31'b0, dbg_valid}, {31'b0, s.v});
            chk("tail dbg_data", dbg_data, s.d);
        end
        @(posedge clk); #1;

        // Reset mid-operation: the stored value is swept away and writes during the sweep are dropped.
        idle_inputs();
        we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        idle_inputs();
        re1 = 1'b1; raddr1 = 5'd9;
        @(negedge clk);
        chk("r9 before reset", rdata1, 32'hA5A5A5A5);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rdata1 during rst", rdata1, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midreset init_done", {31'b0, init_done}, 32'h0);
        chk("midreset dbg_data", dbg_data, 32'h0);
        we = 1'b1; waddr = 5'd9; wdata = 32'h5555AAAA;
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            chk($sformatf("resweep%0d init_done", i), {31'b0, init_done}, 32'h0);
            chk($sformatf("resweep%0d rdata1", i), rdata1, 32'h0);
            @(posedge clk); #1;
        end
        we = 1'b0;
        chk("resweep done init_done", {31'b0, init_done}, 32'h1);
        dbg_re = 1'b1; dbg_addr = 5'd9;
        @(negedge clk);
        chk("r9 after resweep", rdata1, 32'h0);
        @(posedge clk); #1;
        dbg_re = 1'b0;
        chk("dbg r9 valid", {31'b0, dbg_valid}, 32'h1);
        chk("dbg r9 data", dbg_data, 32'h0);
        @(posedge clk); #1;
        chk("dbg r9 valid drop", {31'b0, dbg_valid}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
